// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus master: FSM state codes,
// default strobe timing and the phase-timer reload helper.
package rtc_bus_pkg;

    localparam int T_PW_DEF  = 5;
    localparam int T_AH_DEF  = 2;
    localparam int T_GAP_DEF = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_HOLD = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_DATA      = 3'd4;
    localparam logic [2:0] ST_DATA_END  = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    // The timer ends a phase on the cycle it reads zero, so an N-cycle phase loads N-1.
    function automatic logic [3:0] cnt_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 4-bit down-counter shared by all bus phases; saturates at zero.
module rtc_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/rtc_bus_master.sv
// Bus master for an RTC with a multiplexed address/data bus: address phase,
// fixed gap, then a write or read data phase, all strobes active-low.
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int T_PW   = T_PW_DEF,
    parameter int T_AH   = T_AH_DEF,
    parameter int T_GAP  = T_GAP_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              ad,
    output logic              cs,
    output logic              wr,
    output logic              rd,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);

    localparam logic [3:0] PW_LOAD  = cnt_load(T_PW);
    localparam logic [3:0] AH_LOAD  = cnt_load(T_AH);
    localparam logic [3:0] GAP_LOAD = cnt_load(T_GAP);

    logic [2:0]        state_reg;
    logic              we_reg;
    logic [DATA_W-1:0] addr_reg, wdata_reg, rdata_reg, ad_out_reg;
    logic              ad_reg, cs_reg, wr_reg, rd_reg, oe_reg;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [3:0]        tmr_val;

    rtc_phase_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Timer counts only while a strobe is low or during hold/gap; each phase exit reloads it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tmr_load = req;
                tmr_val  = PW_LOAD;
            end
            ST_ADDR: begin
                if (!wr_reg) begin
                    tmr_load = tmr_zero;
                    tmr_val  = AH_LOAD;
                    tmr_dec  = !tmr_zero;
                end
            end
            ST_ADDR_HOLD: begin
                tmr_load = cs_reg && tmr_zero;
                tmr_val  = GAP_LOAD;
                tmr_dec  = !(cs_reg && tmr_zero);
            end
            ST_GAP: begin
                tmr_load = tmr_zero;
                tmr_val  = PW_LOAD;
                tmr_dec  = !tmr_zero;
            end
            ST_DATA: tmr_dec = !(wr_reg && rd_reg);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            ad_out_reg <= '1;
            ad_reg     <= 1'b1;
            cs_reg     <= 1'b1;
            wr_reg     <= 1'b1;
            rd_reg     <= 1'b1;
            oe_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        we_reg    <= we;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        ad_reg    <= 1'b0;
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (cs_reg) begin
                        cs_reg <= 1'b0;
                    end else if (wr_reg) begin
                        wr_reg     <= 1'b0;
                        oe_reg     <= 1'b1;
                        ad_out_reg <= addr_reg;
                    end else if (tmr_zero) begin
                        wr_reg    <= 1'b1;
                        state_reg <= ST_ADDR_HOLD;
                    end
                end
                ST_ADDR_HOLD: begin
                    // cs rises one cycle after wr, ad one cycle after cs; bus hold runs independently.
                    cs_reg <= 1'b1;
                    if (cs_reg) ad_reg <= 1'b1;
                    if (tmr_zero) begin
                        oe_reg     <= 1'b0;
                        ad_out_reg <= '1;
                    end
                    if (cs_reg && tmr_zero) state_reg <= ST_GAP;
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        cs_reg    <= 1'b0;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_reg && rd_reg) begin
                        if (we_reg) begin
                            wr_reg     <= 1'b0;
                            oe_reg     <= 1'b1;
                            ad_out_reg <= wdata_reg;
                        end else begin
                            rd_reg <= 1'b0;
                        end
                    end else if (tmr_zero) begin
                        wr_reg    <= 1'b1;
                        rd_reg    <= 1'b1;
                        if (!we_reg) rdata_reg <= ad_in;
                        state_reg <= ST_DATA_END;
                    end
                end
                ST_DATA_END: begin
                    cs_reg     <= 1'b1;
                    oe_reg     <= 1'b0;
                    ad_out_reg <= '1;
                    state_reg  <= ST_DONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ready  = (state_reg == ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign rdata  = rdata_reg;
    assign ad     = ad_reg;
    assign cs     = cs_reg;
    assign wr     = wr_reg;
    assign rd     = rd_reg;
    assign ad_oe  = oe_reg;
    assign ad_out = ad_out_reg;

endmodule
